rvvi_retire_buffer: RTL and testbench
=====================================

// Module: rvvi_retire_buffer
// PURPOSE
//  Elastic buffer between a core's retire port and the RVVI coverage sampler (cvw_arch_verif).
//  Captures one retired instruction per cycle and stamps it with a monotonically increasing order number.
//  Presents retire records to the sampler over a valid/ready handshake.
//  Detects and flags lost records when the sampler stalls.
// PARAMETERS
//  XLEN   64  integer register / PC width (32 or 64)
//  DEPTH  8   FIFO entries; power of two, >= 2
// PORTS
//  clk          in   1         clock
//  reset        in   1         synchronous, active-high reset
//  in_valid     in   1         retire event present this cycle
//  in_insn      in   32        retired instruction encoding
//  in_pc        in   XLEN      retired PC
//  in_trap      in   1         instruction trapped
//  in_mode      in   2         privilege mode at retire
//  in_x_wen     in   1         GPR write occurred
//  in_x_rd      in   5         GPR destination index
//  in_x_wdata   in   XLEN      GPR write data
//  out_valid    out  1         record available at head
//  out_ready    in   1         sampler consumes head this cycle
//  out_order    out  64        order stamp of head record
//  out_insn/out_pc/out_trap/out_mode  out  32/XLEN/1/2  head record fields
//  out_x_wb     out  32        one-hot GPR writeback mask (bit rd), 0 if none
//  out_x_wdata  out  XLEN      GPR write data (0 when out_x_wb==0)
//  count        out  $clog2(DEPTH)+1  current occupancy
//  overflow     out  1         sticky: a record was dropped
// BEHAVIOUR
//  - Reset (sync, high): FIFO emptied, order counter = 1, count = 0, overflow = 0;
//    all out_* = 0, out_valid = 0. A reset arriving mid-stream discards all entries; no partial record is emitted.
//  - Order counter: 64-bit. It is incremented on every cycle with in_valid=1, whether the record is accepted or dropped.
//    Each accepted record carries the pre-increment value, so gaps in out_order expose drops. It wraps modulo 2^64.
//  - Push: in_valid && (!full || pop) -> the record is written at the tail.
//  - Drop: in_valid && full && !pop -> the record is discarded and overflow is set. overflow is cleared only by reset.
//  - Pop: out_valid && out_ready -> head advances. out_ready while out_valid=0 is ignored.
//  - Latency: a pushed record is visible on out_* no earlier than the next cycle; there is no combinational bypass.
//    out_* are driven from registers or storage and hold stable while out_valid && !out_ready.
//  - Simultaneous push+pop: count is unchanged. On a full FIFO the push is accepted (not a drop).
//  - Writeback encoding: in_x_wen && in_x_rd!=0 -> x_wb = 1<<rd, wdata kept.
//    If in_x_wen with rd==0, or !in_x_wen -> x_wb = 0 and wdata = 0 (x0 writes are invisible).
//  - Pointers: log2(DEPTH)-bit read and write pointers wrap naturally. full = (count==DEPTH), empty = (count==0).
//  - When out_valid=0, out_* record fields = 0.
// CONFIGURATION
//  RVVI_RETIRE_CSR_EN defined:
//    - Adds ports in_csr_wen (1), in_csr_addr (12), in_csr_wdata (XLEN), out_csr_wen (1), out_csr_addr (12),
//      out_csr_wdata (XLEN).
//    - Each entry stores one CSR write with the same push/drop/pop and reset rules; out_csr_* = 0 when out_valid=0.
//  Not defined: no CSR ports and no CSR storage. All other behaviour is identical.
// TESTING
//  1. Reset, then 3 back-to-back in_valid with out_ready=1 -> out_order 1,2,3, each one cycle after its push;
//     overflow=0, count<=1.
//  2. out_ready=0, DEPTH+1 pushes -> count=DEPTH, overflow=1. Drain yields orders 1..DEPTH;
//     next push gets order DEPTH+2.
//  3. Full FIFO, in_valid=1 and out_ready=1 in the same cycle -> no drop, count stays DEPTH, overflow remains 0.
//  4. Push with in_x_wen=1, rd=0, wdata=0xDEAD -> out_x_wb=0, out_x_wdata=0.
//     Push with rd=5, wdata=0x1234 -> out_x_wb=32'h20, out_x_wdata=0x1234.
//  5. Assert reset with 4 entries queued -> next cycle out_valid=0, count=0, overflow=0; next push carries order 1.
//  6. RVVI_RETIRE_CSR_EN: push csr_wen=1, addr=12'h300, wdata=0x8 -> head shows out_csr_wen=1, addr 0x300, data 0x8.
//     A following push with csr_wen=0 -> out_csr_* = 0.

Source files
------------

// File: rtl/rvvi_retire_buffer.sv
// rvvi_retire_buffer: elastic FIFO between a core retire port and the RVVI
// coverage sampler. Every in_valid cycle consumes one 64-bit order stamp; records
// that find the FIFO full (with no simultaneous pop) are dropped and raise a
// sticky overflow flag. Head fields are gated to zero while the FIFO is empty.
// Optional feature macro: RVVI_RETIRE_CSR_EN adds one CSR write per record.
module rvvi_retire_buffer #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              in_insn,
  input  logic [XLEN-1:0]          in_pc,
  input  logic                     in_trap,
  input  logic [1:0]               in_mode,
  input  logic                     in_x_wen,
  input  logic [4:0]               in_x_rd,
  input  logic [XLEN-1:0]          in_x_wdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              out_order,
  output logic [31:0]              out_insn,
  output logic [XLEN-1:0]          out_pc,
  output logic                     out_trap,
  output logic [1:0]               out_mode,
  output logic [31:0]              out_x_wb,
  output logic [XLEN-1:0]          out_x_wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
`ifdef RVVI_RETIRE_CSR_EN
  ,
  input  logic                     in_csr_wen,
  input  logic [11:0]              in_csr_addr,
  input  logic [XLEN-1:0]          in_csr_wdata,
  output logic                     out_csr_wen,
  output logic [11:0]              out_csr_addr,
  output logic [XLEN-1:0]          out_csr_wdata
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Control state
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   order_q, order_d;
  logic          overflow_q, overflow_d;

  // Record storage (not reset: every read is gated by occupancy)
  logic [63:0]      ord_mem_q   [DEPTH];
  logic [31:0]      insn_mem_q  [DEPTH];
  logic [XLEN-1:0]  pc_mem_q    [DEPTH];
  logic             trap_mem_q  [DEPTH];
  logic [1:0]       mode_mem_q  [DEPTH];
  logic             wb_mem_q    [DEPTH];
  logic [4:0]       rd_mem_q    [DEPTH];
  logic [XLEN-1:0]  wdata_mem_q [DEPTH];
`ifdef RVVI_RETIRE_CSR_EN
  logic             cwen_mem_q  [DEPTH];
  logic [11:0]      caddr_mem_q [DEPTH];
  logic [XLEN-1:0]  cdata_mem_q [DEPTH];
`endif

  logic full_s, empty_s, pop_s, push_s, drop_s, wb_en_s;

  assign full_s  = (count_q == CW'(DEPTH));
  assign empty_s = (count_q == {CW{1'b0}});
  assign pop_s   = !empty_s && out_ready;
  assign push_s  = in_valid && (!full_s || pop_s);
  assign drop_s  = in_valid && full_s && !pop_s;
  // x0 writes carry no architectural effect, so they are recorded as no writeback
  assign wb_en_s = in_x_wen && (in_x_rd != 5'd0);

  // Next-state logic for pointers, occupancy, order stamp and sticky overflow
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    order_d    = order_q;
    overflow_d = overflow_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s && !pop_s) begin
      count_d = count_q + CW'(1);
    end else if (pop_s && !push_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
    if (in_valid) begin
      order_d = order_q + 64'd1;
    end else begin
      order_d = order_q;
    end
    if (drop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      order_q    <= 64'd1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      order_q    <= order_d;
      overflow_q <= overflow_d;
    end
  end

  // Record write at the tail; stamp is the pre-increment order value
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      ord_mem_q[wr_ptr_q]   <= order_q;
      insn_mem_q[wr_ptr_q]  <= in_insn;
      pc_mem_q[wr_ptr_q]    <= in_pc;
      trap_mem_q[wr_ptr_q]  <= in_trap;
      mode_mem_q[wr_ptr_q]  <= in_mode;
      wb_mem_q[wr_ptr_q]    <= wb_en_s;
      rd_mem_q[wr_ptr_q]    <= in_x_rd;
      wdata_mem_q[wr_ptr_q] <= wb_en_s ? in_x_wdata : {XLEN{1'b0}};
`ifdef RVVI_RETIRE_CSR_EN
      cwen_mem_q[wr_ptr_q]  <= in_csr_wen;
      caddr_mem_q[wr_ptr_q] <= in_csr_wen ? in_csr_addr : 12'd0;
      cdata_mem_q[wr_ptr_q] <= in_csr_wen ? in_csr_wdata : {XLEN{1'b0}};
`endif
    end
  end

  // Head presentation, zeroed while the FIFO is empty
  always_comb begin
    out_valid   = !empty_s;
    out_order   = 64'd0;
    out_insn    = 32'd0;
    out_pc      = {XLEN{1'b0}};
    out_trap    = 1'b0;
    out_mode    = 2'd0;
    out_x_wb    = 32'd0;
    out_x_wdata = {XLEN{1'b0}};
`ifdef RVVI_RETIRE_CSR_EN
    out_csr_wen   = 1'b0;
    out_csr_addr  = 12'd0;
    out_csr_wdata = {XLEN{1'b0}};
`endif
    if (!empty_s) begin
      out_order   = ord_mem_q[rd_ptr_q];
      out_insn    = insn_mem_q[rd_ptr_q];
      out_pc      = pc_mem_q[rd_ptr_q];
      out_trap    = trap_mem_q[rd_ptr_q];
      out_mode    = mode_mem_q[rd_ptr_q];
      out_x_wb    = wb_mem_q[rd_ptr_q] ? (32'd1 << rd_mem_q[rd_ptr_q]) : 32'd0;
      out_x_wdata = wdata_mem_q[rd_ptr_q];
`ifdef RVVI_RETIRE_CSR_EN
      out_csr_wen   = cwen_mem_q[rd_ptr_q];
      out_csr_addr  = caddr_mem_q[rd_ptr_q];
      out_csr_wdata = cdata_mem_q[rd_ptr_q];
`endif
    end else begin
      out_order = 64'd0;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_rvvi_retire_buffer.sv
// Testbench for rvvi_retire_buffer: directed scenarios plus random traffic,
// checked against a queue-based model of the retire buffer.
module tb_rvvi_retire_buffer;
  localparam int XLEN  = 64;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, in_valid, in_trap, in_x_wen, out_ready;
  logic [31:0]      in_insn;
  logic [XLEN-1:0]  in_pc, in_x_wdata;
  logic [1:0]       in_mode;
  logic [4:0]       in_x_rd;
  logic             out_valid, out_trap, overflow;
  logic [63:0]      out_order;
  logic [31:0]      out_insn, out_x_wb;
  logic [XLEN-1:0]  out_pc, out_x_wdata;
  logic [1:0]       out_mode;
  logic [$clog2(DEPTH):0] count;
`ifdef RVVI_RETIRE_CSR_EN
  logic             in_csr_wen, out_csr_wen;
  logic [11:0]      in_csr_addr, out_csr_addr;
  logic [XLEN-1:0]  in_csr_wdata, out_csr_wdata;
`endif

  rvvi_retire_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_insn(in_insn), .in_pc(in_pc),
    .in_trap(in_trap), .in_mode(in_mode), .in_x_wen(in_x_wen), .in_x_rd(in_x_rd),
    .in_x_wdata(in_x_wdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_order(out_order), .out_insn(out_insn), .out_pc(out_pc), .out_trap(out_trap),
    .out_mode(out_mode), .out_x_wb(out_x_wb), .out_x_wdata(out_x_wdata),
    .count(count), .overflow(overflow)
`ifdef RVVI_RETIRE_CSR_EN
    , .in_csr_wen(in_csr_wen), .in_csr_addr(in_csr_addr), .in_csr_wdata(in_csr_wdata),
    .out_csr_wen(out_csr_wen), .out_csr_addr(out_csr_addr), .out_csr_wdata(out_csr_wdata)
`endif
  );

  typedef struct {
    logic [63:0] order;
    logic [31:0] insn;
    logic [63:0] pc;
    logic        trap;
    logic [1:0]  mode;
    logic [31:0] xwb;
    logic [63:0] xwd;
    logic        cwen;
    logic [11:0] caddr;
    logic [63:0] cdata;
  } rec_t;

  rec_t        model_q[$];
  logic [63:0] model_order;
  logic        model_ovf;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Compare every DUT output against the model's current head
  task automatic check_outputs();
    rec_t h;
    bit   v;
    v = (model_q.size() > 0);
    h = '{64'd0, 32'd0, 64'd0, 1'b0, 2'd0, 32'd0, 64'd0, 1'b0, 12'd0, 64'd0};
    if (v) h = model_q[0];
    chk("valid", {63'd0, out_valid}, {63'd0, v});
    chk("order", out_order, h.order);
    chk("insn", {32'd0, out_insn}, {32'd0, h.insn});
    chk("pc", out_pc, h.pc);
    chk("trap", {63'd0, out_trap}, {63'd0, h.trap});
    chk("mode", {62'd0, out_mode}, {62'd0, h.mode});
    chk("x_wb", {32'd0, out_x_wb}, {32'd0, h.xwb});
    chk("x_wdata", out_x_wdata, h.xwd);
    chk("count", 64'(count), 64'(model_q.size()));
    chk("overflow", {63'd0, overflow}, {63'd0, model_ovf});
`ifdef RVVI_RETIRE_CSR_EN
    chk("csr_wen", {63'd0, out_csr_wen}, {63'd0, h.cwen});
    chk("csr_addr", {52'd0, out_csr_addr}, {52'd0, h.caddr});
    chk("csr_wdata", out_csr_wdata, h.cdata);
`endif
  endtask

  // One clock: check current state, drive inputs, advance the model, clock edge
  task automatic step(input bit rst, input bit v, input bit rdy, input logic [31:0] insn,
                      input logic [63:0] pc, input bit trap, input logic [1:0] mode,
                      input bit wen, input logic [4:0] rd, input logic [63:0] wd,
                      input bit cw, input logic [11:0] ca, input logic [63:0] cd);
    rec_t r;
    bit   pop, push;
    @(negedge clk);
    check_outputs();
    reset = rst; in_valid = v; out_ready = rdy; in_insn = insn; in_pc = pc;
    in_trap = trap; in_mode = mode; in_x_wen = wen; in_x_rd = rd; in_x_wdata = wd;
`ifdef RVVI_RETIRE_CSR_EN
    in_csr_wen = cw; in_csr_addr = ca; in_csr_wdata = cd;
`endif
    if (rst) begin
      model_q.delete();
      model_order = 64'd1;
      model_ovf   = 1'b0;
    end else begin
      pop  = (model_q.size() > 0) && rdy;
      push = v && ((model_q.size() < DEPTH) || pop);
      r.order = model_order;
      r.insn  = insn; r.pc = pc; r.trap = trap; r.mode = mode;
      r.xwb   = (wen && rd != 5'd0) ? (32'd1 << rd) : 32'd0;
      r.xwd   = (wen && rd != 5'd0) ? wd : 64'd0;
`ifdef RVVI_RETIRE_CSR_EN
      r.cwen  = cw; r.caddr = cw ? ca : 12'd0; r.cdata = cw ? cd : 64'd0;
`else
      r.cwen  = 1'b0; r.caddr = 12'd0; r.cdata = 64'd0;
`endif
      if (v) model_order = model_order + 64'd1;
      if (pop) void'(model_q.pop_front());
      if (push) model_q.push_back(r);
      if (v && !push) model_ovf = 1'b1;
    end
    @(posedge clk);
  endtask

  // Random-payload cycle
  task automatic go(input bit rst, input bit v, input bit rdy);
    step(rst, v, rdy, $urandom, {$urandom, $urandom}, 1'($urandom), 2'($urandom),
         1'($urandom), 5'($urandom), {$urandom, $urandom}, 1'($urandom),
         12'($urandom), {$urandom, $urandom});
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_insn = 32'd0; in_pc = 64'd0;
    in_trap = 1'b0; in_mode = 2'd0; in_x_wen = 1'b0; in_x_rd = 5'd0; in_x_wdata = 64'd0;
`ifdef RVVI_RETIRE_CSR_EN
    in_csr_wen = 1'b0; in_csr_addr = 12'd0; in_csr_wdata = 64'd0;
`endif
    model_order = 64'd1; model_ovf = 1'b0;
    @(posedge clk);

    // Scenario 1: three back-to-back retires drained immediately
    go(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      go(1'b0, 1'b1, 1'b1);
      #1 chk("t1_order", out_order, 64'(i + 1));
    end
    go(1'b0, 1'b0, 1'b1);

    // Scenario 2: DEPTH+1 pushes while stalled, then drain
    go(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) go(1'b0, 1'b1, 1'b0);
    #1 chk("t2_count", 64'(count), 64'(DEPTH));
    chk("t2_ovf", {63'd0, overflow}, 64'd1);
    for (int i = 0; i < DEPTH; i++) begin
      #1 chk("t2_drain", out_order, 64'(i + 1));
      go(1'b0, 1'b0, 1'b1);
    end
    go(1'b0, 1'b1, 1'b0);
    #1 chk("t2_next", out_order, 64'(DEPTH + 2));

    // Scenario 3: full FIFO with simultaneous push and pop
    go(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) go(1'b0, 1'b1, 1'b0);
    go(1'b0, 1'b1, 1'b1);
    #1 chk("t3_count", 64'(count), 64'(DEPTH));
    chk("t3_ovf", {63'd0, overflow}, 64'd0);

    // Scenario 4: writeback encoding
    go(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h13, 64'h100, 1'b0, 2'd3, 1'b1, 5'd0, 64'hDEAD, 1'b0, 12'd0, 64'd0);
    #1 chk("t4_x0_wb", {32'd0, out_x_wb}, 64'd0);
    chk("t4_x0_wd", out_x_wdata, 64'd0);
    step(1'b0, 1'b1, 1'b1, 32'h13, 64'h104, 1'b0, 2'd3, 1'b1, 5'd5, 64'h1234, 1'b0, 12'd0, 64'd0);
    #1 chk("t4_x5_wb", {32'd0, out_x_wb}, 64'h20);
    chk("t4_x5_wd", out_x_wdata, 64'h1234);

    // Scenario 5: reset with entries queued
    go(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) go(1'b0, 1'b1, 1'b0);
    go(1'b1, 1'b1, 1'b0);
    #1 chk("t5_valid", {63'd0, out_valid}, 64'd0);
    chk("t5_count", 64'(count), 64'd0);
    go(1'b0, 1'b1, 1'b0);
    #1 chk("t5_order", out_order, 64'd1);

`ifdef RVVI_RETIRE_CSR_EN
    // Scenario 6: CSR record fields
    go(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h73, 64'h200, 1'b0, 2'd3, 1'b0, 5'd0, 64'd0, 1'b1, 12'h300, 64'h8);
    #1 chk("t6_wen", {63'd0, out_csr_wen}, 64'd1);
    chk("t6_addr", {52'd0, out_csr_addr}, 64'h300);
    chk("t6_data", out_csr_wdata, 64'h8);
    step(1'b0, 1'b1, 1'b1, 32'h13, 64'h204, 1'b0, 2'd3, 1'b0, 5'd0, 64'd0, 1'b0, 12'h305, 64'h9);
    #1 chk("t6_off", {63'd0, out_csr_wen}, 64'd0);
    chk("t6_off_addr", {52'd0, out_csr_addr}, 64'd0);
`endif

    // Random traffic with varying sampler backpressure and occasional resets
    go(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 800; i++) begin
      int rdy_pct;
      rdy_pct = (((i / 60) % 3) == 0) ? 15 : ((((i / 60) % 3) == 1) ? 90 : 55);
      go($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0,
         $urandom_range(0, 99) < rdy_pct);
    end
    @(negedge clk);
    check_outputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
